// File: rtl/hw_phase_timer.sv
// Phase-duration timer for the highway light controller.
// Loads a per-phase duration when the controller's state code changes, counts it
// down in seconds from a clock prescaler, and pulses time_out once on expiry.
module hw_phase_timer #(
    parameter int unsigned CLK_DIV  = 50000000,
    parameter int unsigned T_GREEN  = 25,
    parameter int unsigned T_YELLOW = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] state_hw,
    input  logic       pause,
    output logic       time_out,
    output logic [7:0] sec_left,
    output logic       tick
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
    localparam logic [7:0]      DurGreen = 8'(T_GREEN);
    localparam logic [7:0]      DurYellow = 8'(T_YELLOW);

    // Controller phase codes
    localparam logic [1:0] CodeRed    = 2'b00;
    localparam logic [1:0] CodeGreen  = 2'b01;
    localparam logic [1:0] CodeYellow = 2'b10;
    localparam logic [1:0] CodeIdle   = 2'b11;

    logic [1:0]      state_q, state_d;
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [7:0]      sec_left_q, sec_left_d;
    logic            expired_q, expired_d;
    logic            time_out_q, time_out_d;
    logic            tick_q, tick_d;

    logic            phase_change;
    logic            timed_phase;
    logic            div_wrap;
    logic [7:0]      load_val;

    assign phase_change = (state_hw != state_q);
    assign timed_phase  = (state_q == CodeGreen) || (state_q == CodeYellow);
    assign div_wrap     = (div_cnt_q == DivLast);

    // Duration selected by the incoming phase code
    always_comb begin
        load_val = 8'd0;
        unique case (state_hw)
            CodeGreen:  load_val = DurGreen;
            CodeYellow: load_val = DurYellow;
            CodeRed,
            CodeIdle:   load_val = 8'd0;
            default:    load_val = 8'd0;
        endcase
    end

    // Next-state logic: phase change beats pause and tick; pulses default low
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        sec_left_d = sec_left_q;
        expired_d  = expired_q;
        time_out_d = 1'b0;
        tick_d     = 1'b0;

        if (phase_change) begin
            state_d    = state_hw;
            div_cnt_d  = '0;
            sec_left_d = load_val;
            expired_d  = 1'b0;
        end else if (timed_phase) begin
            if (!expired_q && !pause) begin
                if (div_wrap) begin
                    div_cnt_d = '0;
                    tick_d    = 1'b1;
                    if (sec_left_q > 8'd1) begin
                        sec_left_d = sec_left_q - 8'd1;
                    end else begin
                        // Covers a loaded duration of 0: expires on the first tick
                        sec_left_d = 8'd0;
                        time_out_d = 1'b1;
                        expired_d  = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
        end else begin
            div_cnt_d  = '0;
            sec_left_d = 8'd0;
        end
    end

    // State register; idle code after reset avoids a spurious load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CodeIdle;
            div_cnt_q  <= '0;
            sec_left_q <= 8'd0;
            expired_q  <= 1'b0;
            time_out_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            sec_left_q <= sec_left_d;
            expired_q  <= expired_d;
            time_out_q <= time_out_d;
            tick_q     <= tick_d;
        end
    end

    assign time_out = time_out_q;
    assign sec_left = sec_left_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_hw_phase_timer.sv
// Randomized bench for hw_phase_timer: two instances with different parameters
// checked every cycle against a model built from elapsed counting time.
module tb_hw_phase_timer;

    localparam int unsigned NumDut = 2;
    localparam int unsigned Div0 = 4, Tg0 = 3, Ty0 = 2;
    localparam int unsigned Div1 = 2, Tg1 = 1, Ty1 = 0;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_hw;
    logic       pause;
    logic       to_w   [NumDut];
    logic [7:0] sec_w  [NumDut];
    logic       tick_w [NumDut];

    int n_checks;
    int n_fail;

    // Model state per instance
    int div_p [NumDut];
    int tg_p  [NumDut];
    int ty_p  [NumDut];
    int m_code[NumDut];
    int m_dur [NumDut];
    int m_n   [NumDut];
    bit m_exp [NumDut];
    int e_sec [NumDut];
    int e_to  [NumDut];
    int e_tick[NumDut];
    int to_seen;

    hw_phase_timer #(.CLK_DIV(Div0), .T_GREEN(Tg0), .T_YELLOW(Ty0)) u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .state_hw (state_hw),
        .pause    (pause),
        .time_out (to_w[0]),
        .sec_left (sec_w[0]),
        .tick     (tick_w[0])
    );

    hw_phase_timer #(.CLK_DIV(Div1), .T_GREEN(Tg1), .T_YELLOW(Ty1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .state_hw (state_hw),
        .pause    (pause),
        .time_out (to_w[1]),
        .sec_left (sec_w[1]),
        .tick     (tick_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NumDut; i++) begin
            m_code[i] = 3;
            m_dur[i]  = 0;
            m_n[i]    = 0;
            m_exp[i]  = 1'b0;
            e_sec[i]  = 0;
            e_to[i]   = 0;
            e_tick[i] = 0;
        end
    endtask

    // One clock edge of behaviour, expressed as counting time elapsed since load
    task automatic model_step(input int sh, input bit pz);
        int teff;
        for (int i = 0; i < NumDut; i++) begin
            if (sh != m_code[i]) begin
                m_code[i] = sh;
                m_dur[i]  = (sh == 1) ? tg_p[i] : (sh == 2) ? ty_p[i] : 0;
                m_n[i]    = 0;
                m_exp[i]  = 1'b0;
                e_sec[i]  = m_dur[i];
                e_to[i]   = 0;
                e_tick[i] = 0;
            end else if ((m_code[i] == 1 || m_code[i] == 2) && !m_exp[i] && !pz) begin
                m_n[i]++;
                teff      = (m_dur[i] == 0) ? 1 : m_dur[i];
                e_tick[i] = (m_n[i] % div_p[i] == 0) ? 1 : 0;
                if (m_n[i] == teff * div_p[i]) begin
                    m_exp[i] = 1'b1;
                    e_to[i]  = 1;
                    e_sec[i] = 0;
                end else begin
                    e_to[i]  = 0;
                    e_sec[i] = m_dur[i] - m_n[i] / div_p[i];
                end
            end else begin
                e_to[i]   = 0;
                e_tick[i] = 0;
            end
        end
    endtask

    task automatic check_outputs(input string when);
        for (int i = 0; i < NumDut; i++) begin
            check($sformatf("%s_sec%0d", when, i), int'(sec_w[i]), e_sec[i]);
            check($sformatf("%s_to%0d", when, i), int'(to_w[i]), e_to[i]);
            check($sformatf("%s_tick%0d", when, i), int'(tick_w[i]), e_tick[i]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        to_seen  = 0;
        div_p = '{Div0, Div1};
        tg_p  = '{Tg0, Tg1};
        ty_p  = '{Ty0, Ty1};
        model_reset();

        // Reset held with a timed code present, released with idle
        rst_n    = 1'b0;
        state_hw = 2'b01;
        pause    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs("rst");
        state_hw = 2'b11;
        rst_n    = 1'b1;

        // Quiet idle period: nothing may pulse
        repeat (50) begin
            @(posedge clk);
            model_step(int'(state_hw), pause);
            @(negedge clk);
            check_outputs("idle");
        end

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(posedge clk);
            model_step(int'(state_hw), pause);
            @(negedge clk);
            check_outputs("run");
            if (to_w[0]) to_seen++;

            if ($urandom_range(0, 699) == 0) begin
                // Asynchronous reset mid-run: outputs clear without a clock edge
                rst_n = 1'b0;
                #1;
                model_reset();
                check_outputs("arst");
                @(negedge clk);
                rst_n    = 1'b1;
                state_hw = 2'($urandom_range(1, 2));
                continue;
            end

            // Controller-like advance on expiry, occasional arbitrary jumps
            if (to_w[0] && $urandom_range(0, 1) == 0) begin
                state_hw = (state_hw == 2'b01) ? 2'b10 : 2'b01;
            end else if ($urandom_range(0, 39) == 0) begin
                state_hw = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 11) == 0) pause = ~pause;
        end

        // Stimulus must actually have produced expiries on the main instance
        n_checks++;
        if (to_seen == 0) begin
            n_fail++;
            $display("FAIL expiry_seen: got %0d expected nonzero", to_seen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
